// File: rtl/octave_bin_scheduler_pkg.sv
// Shared scheduler definitions: default bin/octave geometry and FSM state encoding.
// The table modules import the same defaults so all geometry stays consistent.
package cchw_sched_pkg;

  localparam int unsigned BINS = 24;
  localparam int unsigned OCTS = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sched_state_e;

endpackage

// File: rtl/octave_bin_scheduler_if.sv
// Sample-in and datapath-step handshake bundle for the octave/bin scheduler.
// The master side is the sample producer plus datapath; the slave side is the scheduler.
interface octave_bin_scheduler_if
  import cchw_sched_pkg::*;
#(
  parameter int unsigned Bins = BINS,
  parameter int unsigned Octs = OCTS
);
  localparam int unsigned BinW = $clog2(Bins);
  localparam int unsigned OctW = $clog2(Octs);

  logic            in_valid;
  logic            in_ready;
  logic            step_valid;
  logic            step_ready;
  logic [OctW-1:0] step_oct;
  logic [BinW-1:0] step_bin;
  logic            step_first;
  logic            step_last;
  logic [Octs-1:0] increment;
  logic            sample_done;

  modport master (
    output in_valid, step_ready,
    input  in_ready, step_valid, step_oct, step_bin, step_first, step_last, increment,
           sample_done
  );

  modport slave (
    input  in_valid, step_ready,
    output in_ready, step_valid, step_oct, step_bin, step_first, step_last, increment,
           sample_done
  );
endinterface

// File: rtl/octave_bin_scheduler_trailing_ones.sv
// Last due octave for a sample phase: the count of trailing ones in the phase,
// saturated at Octs-1. Octs must be at least 2.
module trailing_ones_count
  import cchw_sched_pkg::*;
#(
  parameter int unsigned Octs = OCTS
) (
  input  logic [Octs-2:0]         i_phase,
  output logic [$clog2(Octs)-1:0] o_last_oct
);
  localparam int unsigned OctW = $clog2(Octs);

  logic [OctW-1:0] w_count;
  logic            w_run;

  always_comb begin
    w_count = '0;
    w_run   = 1'b1;
    for (int i = 0; i < int'(Octs) - 1; i++) begin
      w_run = w_run & i_phase[i];
      if (w_run) w_count = w_count + OctW'(1);
    end
    o_last_oct = (w_count > OctW'(Octs - 1)) ? OctW'(Octs - 1) : w_count;
  end
endmodule

// File: rtl/octave_bin_scheduler.sv
// Walks (octave, bin) steps for each accepted sample; octaves due follow the
// decimation schedule set by the sample phase counter.
module octave_bin_scheduler
  import cchw_sched_pkg::*;
#(
  parameter int unsigned Bins = BINS,
  parameter int unsigned Octs = OCTS
) (
  input  logic                   clk,
  input  logic                   rst,
  octave_bin_scheduler_if.slave  io_sched
);
  localparam int unsigned BinW = $clog2(Bins);
  localparam int unsigned OctW = $clog2(Octs);
  localparam int unsigned PhW  = Octs - 1;

  sched_state_e    r_state, w_state_d;
  logic [PhW-1:0]  r_phase, w_phase_d;
  logic [OctW-1:0] r_oct, w_oct_d;
  logic [BinW-1:0] r_bin, w_bin_d;
  logic [OctW-1:0] r_last, w_last_d;
  logic [OctW-1:0] w_due_last;
  logic            w_fire;

  trailing_ones_count #(
    .Octs (Octs)
  ) u_trailing_ones (
    .i_phase    (r_phase),
    .o_last_oct (w_due_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_phase <= '0;
      r_oct   <= '0;
      r_bin   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_oct   <= w_oct_d;
      r_bin   <= w_bin_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_oct_d   = r_oct;
    w_bin_d   = r_bin;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: begin
        if (io_sched.in_valid) begin
          w_last_d  = w_due_last;
          w_oct_d   = '0;
          w_bin_d   = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (io_sched.step_ready) begin
          if (r_bin != BinW'(Bins - 1)) begin
            w_bin_d = r_bin + BinW'(1);
          end else if (r_oct != r_last) begin
            w_oct_d = r_oct + OctW'(1);
            w_bin_d = '0;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        // Phase advances only once the whole sample has been walked.
        w_phase_d = r_phase + PhW'(1);
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    io_sched.in_ready    = (r_state == StIdle);
    io_sched.step_valid  = (r_state == StRun);
    io_sched.step_oct    = r_oct;
    io_sched.step_bin    = r_bin;
    io_sched.step_first  = (r_state == StRun) && (r_oct == '0) && (r_bin == '0);
    io_sched.step_last   = (r_state == StRun) && (r_oct == r_last)
                           && (r_bin == BinW'(Bins - 1));
    io_sched.sample_done = (r_state == StDone) && !rst;
    // Gated by rst so an aborted step never bumps a table counter.
    w_fire               = io_sched.step_valid && io_sched.step_ready && !rst;
    io_sched.increment   = '0;
    for (int i = 0; i < int'(Octs); i++) begin
      io_sched.increment[i] = w_fire && (r_oct == OctW'(i));
    end
  end
endmodule

// File: tb/tb_octave_bin_scheduler.sv
// Directed bench for octave_bin_scheduler: full 16-sample schedule, wrap, stalls,
// held in_valid and mid-sample reset, each step checked against hand-derived values.
module tb_octave_bin_scheduler;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  octave_bin_scheduler_if sif ();

  octave_bin_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .io_sched (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs_vec();
    return {sif.step_valid, sif.step_oct, sif.step_bin, sif.step_first, sif.step_last,
            sif.increment, sif.in_ready};
  endfunction

  // One sample with last due octave l; optional stalls, held in_valid, abort at a step index.
  task automatic run_sample(input int l, input bit stall, input bit hold, input int abort_at);
    int         n;
    int         idx;
    int         budget;
    int         wait_cnt;
    int         per_oct[5];
    logic [4:0] inc;
    n        = 24 * (l + 1);
    idx      = 0;
    budget   = 0;
    wait_cnt = 0;
    for (int o = 0; o < 5; o++) per_oct[o] = 0;
    while (!sif.in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk("idle_ready", 32'(sif.in_ready), 32'd1);
    sif.in_valid = 1'b1;
    @(negedge clk);
    if (!hold) sif.in_valid = 1'b0;
    budget = 0;
    while (idx < n && budget < 2000) begin
      if (stall)
        sif.step_ready = (wait_cnt >= 2)
                         || (idx != 0 && idx != n - 1 && $urandom_range(0, 2) != 0);
      else
        sif.step_ready = 1'b1;
      #1;
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_cycle_quiet", 32'({sif.increment, sif.sample_done}), 32'd0);
        @(negedge clk);
        rst            = 1'b0;
        sif.in_valid   = 1'b0;
        sif.step_ready = 1'b0;
        #1;
        chk("rst_idle", 32'({sif.in_ready, sif.step_valid, sif.sample_done}), 32'b100);
        @(negedge clk);
        chk("rst_no_done", 32'({sif.in_ready, sif.step_valid, sif.sample_done}), 32'b100);
        return;
      end
      inc = sif.step_ready ? (5'd1 << (idx / 24)) : 5'd0;
      chk("step", 32'(obs_vec()),
          32'({1'b1, 3'(idx / 24), 5'(idx % 24), idx == 0, idx == n - 1, inc, 1'b0}));
      for (int o = 0; o < 5; o++) if (sif.increment[o]) per_oct[o]++;
      if (sif.step_ready) begin
        idx++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
      @(negedge clk);
      budget++;
    end
    chk("step_count", 32'(idx), 32'(n));
    sif.step_ready = 1'b0;
    #1;
    chk("done_pulse", 32'({sif.sample_done, sif.step_valid, sif.in_ready}), 32'b100);
    @(negedge clk);
    chk("ready_back", 32'({sif.sample_done, sif.step_valid, sif.in_ready}), 32'b001);
    sif.in_valid = 1'b0;
    if (stall) begin
      for (int o = 0; o < 5; o++) chk("inc_per_oct", 32'(per_oct[o]), (o <= l) ? 32'd24 : 32'd0);
    end
  endtask

  initial begin
    int exp_l[16];
    exp_l = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 4};
    rst            = 1'b1;
    sif.in_valid   = 1'b0;
    sif.step_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'({sif.step_valid, sif.step_first, sif.step_last, sif.increment,
                            sif.sample_done, sif.in_ready}), 32'd1);
    // Phases 0..15: P=2 holds in_valid through RUN, P=15 runs with stalls.
    for (int p = 0; p < 16; p++) run_sample(exp_l[p], p == 15, p == 2, -1);
    run_sample(0, 1'b0, 1'b0, -1);
    run_sample(1, 1'b0, 1'b0, 30);
    run_sample(0, 1'b0, 1'b0, -1);
    run_sample(1, 1'b0, 1'b0, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/octave_bin_scheduler.md
# octave_bin_scheduler

Sequences the per-bin DFT datapath across all bins and octaves for each accepted input sample. It sits between the sample input stage and the sin/cos tables, per-octave table counters and accumulators. Per sample it computes how many octaves are due under the decimation schedule, then walks (octave, bin) pairs through a valid/ready step interface. It pulses the matching per-octave table-counter increment as each step is accepted.

## Interface
- BINS, 24, bins per octave; step_bin width is $clog2(BINS)
- OCTS, 5, octaves; step_oct width is $clog2(OCTS); sample phase counter is OCTS-1 bits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  new input sample available
- in_ready  out  1  scheduler idle and able to accept a sample
- step_valid  out  1  step_oct/step_bin describe a pending datapath step
- step_ready  in  1  datapath accepts the current step
- step_oct  out  $clog2(OCTS)  octave of the current step
- step_bin  out  $clog2(BINS)  bin of the current step; also the table bin select
- step_first  out  1  current step is the first step for this sample
- step_last  out  1  current step is the last step for this sample
- increment  out  OCTS  one-hot; bit step_oct = step_valid & step_ready
- sample_done  out  1  one-cycle pulse, cycle after the last step is accepted

## Operation
- Phase counter P (OCTS-1 bits) counts accepted samples and wraps modulo 2^(OCTS-1).
- Octave o is due for a sample when the low o bits of P are all ones. Octave 0 is always due.
- The due octaves are therefore always contiguous from 0. Capture the last due octave at acceptance: L = min(trailing_ones(P), OCTS-1).
- State IDLE: in_ready=1, step_valid=0.
  - On in_valid: capture L, set oct=0, bin=0, go to RUN.
  - P is not changed at acceptance.
- State RUN: in_ready=0, step_valid=1.
  - On step_ready, advance:
    - If bin<BINS-1: bin+1.
    - Else if oct<L: oct+1, bin=0.
    - Else (final step): go to DONE.
  - Without step_ready: hold all outputs stable.
- State DONE (one cycle): sample_done=1, P<=P+1, then go to IDLE.
- step_first = RUN & oct==0 & bin==0.
- step_last = RUN & oct==L & bin==BINS-1.
- Steps per sample = BINS*(L+1). Defaults: 24, 48, 72, 96 or 120.
- in_valid outside IDLE is ignored. The producer holds it until in_ready.

## Timing
- Reset values:
  - state IDLE, P=0, oct=0, bin=0, L=0
  - in_ready=1 from the first cycle after reset
  - step_valid, step_first, step_last, increment, sample_done all 0
- Accept at edge t (in_valid&in_ready). step_valid=1 at t+1 with (0,0).
- With step_ready held high: one step per cycle, so the last step is accepted at t+BINS*(L+1).
  - sample_done pulses in the following cycle.
  - in_ready returns the cycle after that.
  - Issue interval = BINS*(L+1)+2 cycles.
- increment is combinational from the handshake and asserts in the same cycle as acceptance. The table counter advances at that edge.
- Stalls (step_ready=0) may occur on any step, including the first and the last. Nothing advances during a stall.
- rst mid-sample aborts immediately:
  - P=0, IDLE
  - no sample_done and no increment in the reset cycle
- P wraps from 2^(OCTS-1)-1 to 0. The sample with P=all ones has L=OCTS-1 (all octaves).

## Structure
- Shared package cchw_sched_pkg:
  - state enum {IDLE, RUN, DONE}
  - default BINS/OCTS constants, also used by the table modules
- One sub-module, trailing_ones_count: combinational, P to L with saturation at OCTS-1.
- Everything else lives in a single always_ff plus output decode.

## Test plan
- Reset then a single in_valid with step_ready=1 → 24 steps, (0,0)..(0,23); step_first on step 0, step_last on step 23; increment=5'b00001 each cycle; sample_done next cycle; P=1.
- Second sample (P=1) → 48 steps, octave 0 bins 0–23 then octave 1 bins 0–23; increment switches to 5'b00010 at step 24.
- Sixteen back-to-back samples → step counts 24,48,24,72,24,48,24,96,…,120 at P=15; P wraps to 0 and the 17th sample gives 24 steps.
- Random step_ready stalls during the P=15 sample → step sequence identical to the unstalled run; exactly 120 increment pulses total, 24 per octave bit.
- in_valid held high during RUN → no extra acceptance; in_ready low until the cycle after sample_done.
- rst asserted at step 30 of a 48-step sample → next cycle IDLE, in_ready=1, P=0, no sample_done; the next sample produces 24 steps.
